stepper_pulse_gen: RTL and testbench
====================================

Name: stepper_pulse_gen

Overview:
- Parametrised N-channel step/direction pulse generator in the FPGA fabric. Replaces the fixed five-channel speed/steps PIO pairs with hardware step timing.
- The HPS writes a step count, direction and period per channel, then pulses load. The block emits exact step pulses, reports remaining steps and aborts on endstop or global abort.
- Sits between the HPS-facing PIO/CSR bridge and the stepper driver pins.

Parameters:
- N_CH, 5, number of stepper channels.
- STEP_W, 32, width of step count and remaining counter.
- PERIOD_W, 32, width of step period in clk_clk cycles.
- PULSE_CYC, 50, step_out high time in cycles.
- DIR_SETUP_CYC, 20, cycles from dir_out settling to first step_out rise.
- HOME_DIR, {N_CH{1'b0}}, per-channel dir_out value that moves toward that channel's endstop.

Ports:
- clk_clk  in  1  system clock; the only clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- cmd_load  in  N_CH  one-cycle load strobe per channel.
- cmd_steps  in  N_CH*STEP_W  step count; channel i occupies [i*STEP_W +: STEP_W].
- cmd_dir  in  N_CH  direction per channel.
- cmd_period  in  N_CH*PERIOD_W  rise-to-rise step period in cycles.
- abort_all  in  1  global stop, level-sensitive.
- endstop_raw  in  N_CH  asynchronous endstop inputs, active high.
- endstop_en  in  N_CH  endstop abort enable per channel.
- step_out  out  N_CH  step pulses.
- dir_out  out  N_CH  direction to drivers.
- busy  out  N_CH  channel is executing a move.
- remaining  out  N_CH*STEP_W  steps not yet issued.
- hit  out  N_CH  sticky flag: move ended by endstop.

Behaviour:
- Reset: all outputs 0, all channels IDLE, synchronizers cleared.
- Channels are fully independent except for the shared abort_all.
- endstop_raw passes through a 2-flop synchronizer; es_sync is the synchronized value. Effective latency is 2 cycles.
- eff_period = max(cmd_period, 2*PULSE_CYC), latched at load. A period of 0 clamps to 2*PULSE_CYC.
- States: IDLE, SETUP, PHIGH, PLOW.
- IDLE + cmd_load, accepted (edge k):
  - Latch steps, period and dir.
  - dir_out = cmd_dir; hit = 0; remaining = cmd_steps; busy = 1; go to SETUP. All take effect at edge k.
- Load with steps == 0: remaining = 0, busy stays 0, hit cleared, dir_out updated.
- Load rejected (remaining = cmd_steps, busy stays 0, hit = 1) when all of:
  - endstop_en[i] = 1,
  - es_sync[i] = 1,
  - cmd_dir[i] == HOME_DIR[i].
- Load while busy: ignored; no state change.
- Load in the same cycle as abort_all high: ignored.
- SETUP: counts DIR_SETUP_CYC cycles, so step_out rises at edge k+DIR_SETUP_CYC. Go to PHIGH.
- PHIGH:
  - remaining decrements on the same edge step_out rises.
  - step_out stays high PULSE_CYC cycles, then go to PLOW.
- PLOW:
  - Holds until eff_period cycles have passed since the last rise.
  - Then, if remaining > 0, go to PHIGH (next rise); else go to IDLE with busy = 0.
  - busy therefore falls eff_period cycles after the final rise.
- Abort condition: abort_all, OR (endstop_en & es_sync & dir_out == HOME_DIR).
- Abort in SETUP or PLOW: go to IDLE at the next edge, busy = 0.
- Abort in PHIGH: finish the full PULSE_CYC high time (no runt pulse), then go to IDLE.
- On abort, remaining holds the count of unissued steps. hit = 1 only for an endstop abort, not for abort_all.
- An endstop on the side opposite HOME_DIR never aborts.
- Counters: a period counter (PERIOD_W) runs from each rise. The pulse and setup counters are sized $clog2 of their max. remaining never underflows.
- dir_out changes only on an accepted load.

Decomposition:
- Shared package stepper_pkg:
  - state enum (IDLE, SETUP, PHIGH, PLOW),
  - default widths,
  - the MIN_PERIOD function 2*PULSE_CYC.
- Sub-module stepper_channel:
  - one FSM plus counters, plus its synchronizer;
  - instantiated N_CH times by a generate loop in the top level, which only slices the vectors and fans out abort_all.

Test Plan:
- Ch0 load steps=3, period=200, dir=1 -> step_out rises at k+20, k+220, k+420, each 50 cycles high; remaining 2,1,0; busy falls at k+620.
- Ch1 period=10 (< 100) -> rises 100 cycles apart; period=0 -> same 100-cycle spacing.
- Ch2 HOME_DIR=0, en=1, dir=0, steps=1000, endstop raised mid-PHIGH -> pulse completes its full 50 cycles; busy=0; hit=1; remaining frozen. Repeat with dir=1 -> no abort.
- abort_all raised with ch0 and ch3 busy -> both reach IDLE within PULSE_CYC+1 cycles; hit stays 0. A simultaneous load on ch4 is ignored.
- Load on busy ch0 with new values -> ignored; the original move completes unchanged. Load with steps=0 -> busy never asserts.
- Reset asserted mid-move -> step_out, busy and remaining go to 0 immediately (asynchronously). After release, a new load is accepted.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types, default widths and timing helpers for the step/direction pulse generator.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PHIGH = 2'd2,
        PLOW  = 2'd3
    } state_e;

    localparam int unsigned DEF_N_CH          = 5;
    localparam int unsigned DEF_STEP_W        = 32;
    localparam int unsigned DEF_PERIOD_W      = 32;
    localparam int unsigned DEF_PULSE_CYC     = 50;
    localparam int unsigned DEF_DIR_SETUP_CYC = 20;

    // Shortest legal rise-to-rise spacing: equal high and low times.
    function automatic int unsigned min_period(input int unsigned pulse_cyc);
        return 2 * pulse_cyc;
    endfunction

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
// One step/direction channel: endstop synchronizer, move FSM, setup/pulse/period counters
// and the remaining-steps counter.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_W        = DEF_STEP_W,
    parameter int unsigned PERIOD_W      = DEF_PERIOD_W,
    parameter int unsigned PULSE_CYC     = DEF_PULSE_CYC,
    parameter int unsigned DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
    parameter logic        HOME_DIR      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [STEP_W-1:0]   steps,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period,
    input  logic                abort_all,
    input  logic                endstop_raw,
    input  logic                endstop_en,
    output logic                step_out,
    output logic                dir_out,
    output logic                busy,
    output logic [STEP_W-1:0]   remaining,
    output logic                hit
);

    localparam int unsigned         SETUP_W      = cnt_width(DIR_SETUP_CYC);
    localparam int unsigned         PULSE_W      = cnt_width(PULSE_CYC);
    localparam logic [SETUP_W-1:0]  SETUP_LAST   = SETUP_W'(DIR_SETUP_CYC - 1);
    localparam logic [PULSE_W-1:0]  PULSE_LAST   = PULSE_W'(PULSE_CYC - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_FLOOR = PERIOD_W'(min_period(PULSE_CYC));

    state_e              state, state_nxt;
    logic                es_meta, es_sync;
    logic [SETUP_W-1:0]  setup_cnt;
    logic [PULSE_W-1:0]  pulse_cnt;
    logic [PERIOD_W-1:0] period_cnt, period_last, eff_period;
    logic                abort_pend, es_pend;
    logic                es_abort, abort_now, load_ok, load_reject, start;
    logic                rise, pulse_done, period_done;

    // Endstop only counts when the channel is heading toward it.
    assign es_abort    = endstop_en & es_sync & (dir_out == HOME_DIR);
    assign abort_now   = abort_all | es_abort;
    assign load_ok     = (state == IDLE) & load & ~abort_all;
    assign load_reject = endstop_en & es_sync & (dir == HOME_DIR);
    assign start       = load_ok & ~load_reject & (steps != '0);
    assign pulse_done  = (pulse_cnt == PULSE_LAST);
    assign period_done = (period_cnt == period_last);
    assign rise        = (state_nxt == PHIGH) & (state != PHIGH);
    assign eff_period  = (period < PERIOD_FLOOR) ? PERIOD_FLOOR : period;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: begin
                if (abort_now)                    state_nxt = IDLE;
                else if (setup_cnt == SETUP_LAST) state_nxt = PHIGH;
            end
            // An abort during the high time waits for the pulse to finish: no runt pulses.
            PHIGH: if (pulse_done) state_nxt = (abort_now || abort_pend) ? IDLE : PLOW;
            PLOW: begin
                if (abort_now)        state_nxt = IDLE;
                else if (period_done) state_nxt = (remaining != '0) ? PHIGH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        step_out = (state == PHIGH);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            es_meta     <= 1'b0;
            es_sync     <= 1'b0;
            setup_cnt   <= '0;
            pulse_cnt   <= '0;
            period_cnt  <= '0;
            period_last <= '0;
            abort_pend  <= 1'b0;
            es_pend     <= 1'b0;
            remaining   <= '0;
            hit         <= 1'b0;
            dir_out     <= 1'b0;
        end else begin
            es_meta    <= endstop_raw;
            es_sync    <= es_meta;
            setup_cnt  <= (state == SETUP) ? setup_cnt + 1'b1 : '0;
            pulse_cnt  <= (state == PHIGH) ? pulse_cnt + 1'b1 : '0;
            period_cnt <= (rise || state == IDLE) ? '0 : period_cnt + 1'b1;

            if (state == PHIGH) begin
                abort_pend <= abort_pend | abort_now;
                es_pend    <= es_pend | es_abort;
            end else begin
                abort_pend <= 1'b0;
                es_pend    <= 1'b0;
            end

            if (load_ok)   remaining <= steps;
            else if (rise) remaining <= remaining - 1'b1;

            if (load_ok && !load_reject) begin
                dir_out     <= dir;
                period_last <= eff_period - 1'b1;
            end

            if (load_ok)
                hit <= load_reject;
            else if ((state == SETUP || state == PLOW) && abort_now)
                hit <= es_abort;
            else if (state == PHIGH && pulse_done && (es_abort || es_pend))
                hit <= 1'b1;
        end
    end

endmodule

// File: rtl/stepper_pulse_gen.sv
// N-channel step/direction pulse generator: slices the packed command/status vectors
// and fans the shared abort out to independent channels.
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int unsigned     N_CH          = DEF_N_CH,
    parameter int unsigned     STEP_W        = DEF_STEP_W,
    parameter int unsigned     PERIOD_W      = DEF_PERIOD_W,
    parameter int unsigned     PULSE_CYC     = DEF_PULSE_CYC,
    parameter int unsigned     DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
    parameter logic [N_CH-1:0] HOME_DIR      = '0
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [N_CH-1:0]            cmd_load,
    input  logic [N_CH*STEP_W-1:0]     cmd_steps,
    input  logic [N_CH-1:0]            cmd_dir,
    input  logic [N_CH*PERIOD_W-1:0]   cmd_period,
    input  logic                       abort_all,
    input  logic [N_CH-1:0]            endstop_raw,
    input  logic [N_CH-1:0]            endstop_en,
    output logic [N_CH-1:0]            step_out,
    output logic [N_CH-1:0]            dir_out,
    output logic [N_CH-1:0]            busy,
    output logic [N_CH*STEP_W-1:0]     remaining,
    output logic [N_CH-1:0]            hit
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        stepper_channel #(
            .STEP_W        (STEP_W),
            .PERIOD_W      (PERIOD_W),
            .PULSE_CYC     (PULSE_CYC),
            .DIR_SETUP_CYC (DIR_SETUP_CYC),
            .HOME_DIR      (HOME_DIR[i])
        ) u_ch (
            .clk         (clk_clk),
            .rst_n       (reset_reset_n),
            .load        (cmd_load[i]),
            .steps       (cmd_steps[i*STEP_W +: STEP_W]),
            .dir         (cmd_dir[i]),
            .period      (cmd_period[i*PERIOD_W +: PERIOD_W]),
            .abort_all   (abort_all),
            .endstop_raw (endstop_raw[i]),
            .endstop_en  (endstop_en[i]),
            .step_out    (step_out[i]),
            .dir_out     (dir_out[i]),
            .busy        (busy[i]),
            .remaining   (remaining[i*STEP_W +: STEP_W]),
            .hit         (hit[i])
        );
    end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Scoreboard bench for stepper_pulse_gen: an arithmetic move model predicts every busy/step
// edge per channel; a negedge monitor pops and compares whatever the DUT actually produces.
module tb_stepper_pulse_gen;

    localparam int N_CH     = 5;
    localparam int STEP_W   = 32;
    localparam int PERIOD_W = 32;
    localparam int PULSE    = 50;
    localparam int SETUP    = 20;
    localparam int MIN_P    = 2 * PULSE;

    localparam int EV_START = 0;
    localparam int EV_RISE  = 1;
    localparam int EV_FALL  = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int ch;
        int kind;
        int t;
        int rem;
        bit hit;
        bit dir;
    } ev_t;

    logic                     clk_clk = 1'b0;
    logic                     reset_reset_n;
    logic [N_CH-1:0]          cmd_load;
    logic [N_CH*STEP_W-1:0]   cmd_steps;
    logic [N_CH-1:0]          cmd_dir;
    logic [N_CH*PERIOD_W-1:0] cmd_period;
    logic                     abort_all;
    logic [N_CH-1:0]          endstop_raw;
    logic [N_CH-1:0]          endstop_en;
    logic [N_CH-1:0]          step_out;
    logic [N_CH-1:0]          dir_out;
    logic [N_CH-1:0]          busy;
    logic [N_CH*STEP_W-1:0]   remaining;
    logic [N_CH-1:0]          hit;

    ev_t             sb[$];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    bit              mon_en = 1'b0;
    logic [N_CH-1:0] prev_step = '0;
    logic [N_CH-1:0] prev_busy = '0;
    int              free_at[N_CH];

    stepper_pulse_gen dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cmd_load      (cmd_load),
        .cmd_steps     (cmd_steps),
        .cmd_dir       (cmd_dir),
        .cmd_period    (cmd_period),
        .abort_all     (abort_all),
        .endstop_raw   (endstop_raw),
        .endstop_en    (endstop_en),
        .step_out      (step_out),
        .dir_out       (dir_out),
        .busy          (busy),
        .remaining     (remaining),
        .hit           (hit)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int kind, input int t, input int rem,
                        input bit h, input bit d);
        ev_t e;
        e.ch = ch; e.kind = kind; e.t = t; e.rem = rem; e.hit = h; e.dir = d;
        sb.push_back(e);
    endtask

    // Move model: rise j at k+SETUP+j*eff; an abort first seen at edge abort_edge ends the
    // move there, unless the pulse is high, in which case the pulse completes first.
    task automatic plan_move(input int ch, input int k, input int steps, input int period,
                             input bit dir, input int abort_edge, input bit by_endstop,
                             output int end_t);
        int eff, r, issued;
        bit aborted;
        eff = (period < MIN_P) ? MIN_P : period;
        issued = 0; aborted = 1'b0; end_t = 0; r = k + SETUP;
        push(ch, EV_START, k, 0, 1'b0, 1'b0);
        for (int j = 0; j < steps && !aborted; j++) begin
            r = k + SETUP + j * eff;
            if (abort_edge != 0 && abort_edge <= r) begin
                aborted = 1'b1;
                end_t = abort_edge;
            end else begin
                push(ch, EV_RISE, r, steps - 1 - j, 1'b0, 1'b0);
                push(ch, EV_FALL, r + PULSE, 0, 1'b0, 1'b0);
                issued++;
                if (abort_edge != 0 && abort_edge <= r + PULSE) begin
                    aborted = 1'b1;
                    end_t = r + PULSE;
                end
            end
        end
        if (!aborted) begin
            end_t = r + eff;
            if (abort_edge != 0 && abort_edge <= end_t) begin
                aborted = 1'b1;
                end_t = abort_edge;
            end
        end
        push(ch, EV_DONE, end_t, steps - issued, aborted && by_endstop, dir);
    endtask

    task automatic observe(input int ch, input int kind);
        int  idx;
        ev_t e;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].ch == ch) idx = i;
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: ch%0d kind %0d at cycle %0d, nothing expected",
                     ch, kind, cyc);
        end else begin
            e = sb[idx];
            sb.delete(idx);
            check($sformatf("ch%0d_event_kind", ch), kind, e.kind);
            check($sformatf("ch%0d_event_time", ch), cyc, e.t);
            if (kind == EV_RISE || kind == EV_DONE)
                check($sformatf("ch%0d_remaining", ch), remaining[ch*STEP_W +: STEP_W], e.rem);
            if (kind == EV_DONE) begin
                check($sformatf("ch%0d_hit", ch), hit[ch], e.hit);
                check($sformatf("ch%0d_dir_out", ch), dir_out[ch], e.dir);
            end
        end
    endtask

    always @(negedge clk_clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (busy[ch] && !prev_busy[ch])     observe(ch, EV_START);
                if (step_out[ch] && !prev_step[ch]) observe(ch, EV_RISE);
                if (!step_out[ch] && prev_step[ch]) observe(ch, EV_FALL);
                if (!busy[ch] && prev_busy[ch])     observe(ch, EV_DONE);
            end
        end
        prev_step <= step_out;
        prev_busy <= busy;
    end

    task automatic set_cmd(input int ch, input int steps, input int period, input bit dir);
        cmd_load[ch]                         = 1'b1;
        cmd_steps[ch*STEP_W +: STEP_W]       = steps;
        cmd_period[ch*PERIOD_W +: PERIOD_W]  = period;
        cmd_dir[ch]                          = dir;
    endtask

    task automatic launch(input int ch, input int steps, input int period, input bit dir,
                          output int k, output int end_t);
        @(negedge clk_clk);
        k = cyc + 1;
        set_cmd(ch, steps, period, dir);
        plan_move(ch, k, steps, period, dir, 0, 1'b0, end_t);
        @(negedge clk_clk);
        cmd_load = '0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int k, k1, t_end, ch, st, per;
        bit d;

        reset_reset_n = 1'b0;
        cmd_load      = '0;
        cmd_steps     = '0;
        cmd_dir       = '0;
        cmd_period    = '0;
        abort_all     = 1'b0;
        endstop_raw   = '0;
        endstop_en    = '0;
        repeat (3) @(negedge clk_clk);
        check("reset_step_out", step_out, 0);
        check("reset_busy", busy, 0);
        check("reset_dir_out", dir_out, 0);
        check("reset_hit", hit, 0);
        check("reset_remaining", remaining, 0);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        mon_en = 1'b1;

        // Basic timing on ch0, clamped periods on ch1, and a load into busy ch0.
        launch(0, 3, 200, 1'b1, k, t_end);
        launch(1, 3, 10, 1'b0, k1, t_end);
        wait_until(k + 100);
        set_cmd(0, 9, 0, 1'b0);
        @(negedge clk_clk);
        cmd_load = '0;
        wait_drain(3000);
        check("busy_load_dir_kept", dir_out[0], 1);
        launch(1, 2, 0, 1'b1, k1, t_end);
        wait_drain(3000);

        // Endstop toward home during the first pulse on ch2.
        endstop_en = 5'b00100;
        @(negedge clk_clk);
        k = cyc + 1;
        set_cmd(2, 1000, 150, 1'b0);
        plan_move(2, k, 1000, 150, 1'b0, k + 33, 1'b1, t_end);
        @(negedge clk_clk);
        cmd_load = '0;
        wait_until(k + 30);
        endstop_raw[2] = 1'b1;
        wait_drain(3000);

        // Load toward a tripped endstop is rejected.
        @(negedge clk_clk);
        set_cmd(2, 7, 100, 1'b0);
        @(negedge clk_clk);
        cmd_load = '0;
        @(negedge clk_clk);
        check("reject_remaining", remaining[2*STEP_W +: STEP_W], 7);
        check("reject_hit", hit[2], 1);
        check("reject_busy", busy[2], 0);

        // Zero-step load: updates dir, clears hit, never goes busy.
        set_cmd(2, 0, 100, 1'b1);
        @(negedge clk_clk);
        cmd_load = '0;
        @(negedge clk_clk);
        check("zero_steps_remaining", remaining[2*STEP_W +: STEP_W], 0);
        check("zero_steps_hit", hit[2], 0);
        check("zero_steps_dir", dir_out[2], 1);
        check("zero_steps_busy", busy[2], 0);

        // Moving away from the tripped endstop runs to completion.
        launch(2, 2, 100, 1'b1, k, t_end);
        wait_drain(3000);
        endstop_raw = '0;
        endstop_en  = '0;
        repeat (4) @(negedge clk_clk);

        // Global abort with ch0 high and ch3 low; concurrent ch4 load is ignored.
        @(negedge clk_clk);
        k = cyc + 1;
        set_cmd(0, 4, 300, 1'b0);
        set_cmd(3, 4, 120, 1'b1);
        plan_move(0, k, 4, 300, 1'b0, k + 331, 1'b0, t_end);
        plan_move(3, k, 4, 120, 1'b1, k + 331, 1'b0, t_end);
        @(negedge clk_clk);
        cmd_load = '0;
        wait_until(k + 330);
        abort_all = 1'b1;
        set_cmd(4, 5, 100, 1'b1);
        @(negedge clk_clk);
        cmd_load = '0;
        repeat (60) @(negedge clk_clk);
        abort_all = 1'b0;
        wait_drain(1000);
        check("abort_load_busy", busy[4], 0);
        check("abort_load_remaining", remaining[4*STEP_W +: STEP_W], 0);
        check("abort_load_dir", dir_out[4], 0);

        // Asynchronous reset in the middle of a pulse, then a fresh move.
        launch(1, 3, 200, 1'b0, k, t_end);
        wait_until(k + 30);
        mon_en = 1'b0;
        sb.delete();
        #2 reset_reset_n = 1'b0;
        #1;
        check("async_reset_step_out", step_out, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_remaining", remaining, 0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        mon_en = 1'b1;
        launch(1, 2, 100, 1'b1, k, t_end);
        wait_drain(2000);

        // Randomised independent moves on all channels.
        for (int i = 0; i < N_CH; i++) free_at[i] = cyc;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(1, 150)) @(negedge clk_clk);
            ch = $urandom_range(0, N_CH - 1);
            if (cyc + 1 > free_at[ch]) begin
                st  = $urandom_range(1, 4);
                per = $urandom_range(0, 260);
                d   = 1'($urandom_range(0, 1));
                launch(ch, st, per, d, k, t_end);
                free_at[ch] = t_end;
            end
        end
        wait_drain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
